// File: rtl/priority_grant_arbiter.sv
// priority_grant_arbiter
//   Registered, locking N-way arbiter. One requester owns the grant until it
//   drops its request line. Arbitration is fixed priority (index 0 highest) or
//   round-robin (RR_MODE=1), starting the scan at rr_ptr.
//
//   Optional build macro PRIORITY_ARB_TIMEOUT_EN: limits a tenure to MAX_HOLD
//   cycles when someone else is waiting, and pulses timeout_out on the handover.
//   Without the macro there is no hold counter and timeout_out is tied low.
module priority_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] gnt_out,
  output logic [IDX_W-1:0]   gnt_idx_out,
  output logic               gnt_valid_out,
  output logic               timeout_out
);

  // Reject illegal configurations at elaboration time.
  if (NUM_REQ < 1 || NUM_REQ > 32) begin : g_bad_num_req
    $error("priority_grant_arbiter: NUM_REQ must be 1..32");
  end
  if (RR_MODE != 0 && RR_MODE != 1) begin : g_bad_rr_mode
    $error("priority_grant_arbiter: RR_MODE must be 0 or 1");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("priority_grant_arbiter: MAX_HOLD must be 2..65535");
  end

  localparam logic [IDX_W:0]   NUM_REQ_X = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [IDX_W:0]      win;        // {found, index}
  logic [IDX_W-1:0]    rel_ptr;    // scan start used on a release / handover
  logic                owner_req;  // owner still holding its request

`ifdef PRIORITY_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0]         hold_cnt_q, hold_cnt_d;
  logic                timeout_q, timeout_d;
  logic                others_req;
`endif

  // First set bit of req scanning ptr, ptr+1, ... modulo NUM_REQ.
  // The request vector is rotated right by ptr so the scan becomes a plain
  // lowest-set-bit search; the offset is then added back with one wrap.
  // Fixed mode always passes ptr=0, which degenerates to lowest index wins.
  function automatic logic [IDX_W:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W:0]       off;
    logic [IDX_W:0]       sum;
    logic                 found;
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(k);
      end
    end
    sum = off + {1'b0, ptr};
    if (sum >= NUM_REQ_X) sum = sum - NUM_REQ_X;
    return {found, sum[IDX_W-1:0]};
  endfunction

  // State register: FSM state, grant, owner index, rr pointer, hold counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
`ifdef PRIORITY_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef PRIORITY_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Next-state: grant from idle, hold while owner requests, hand over on
  // release with no idle bubble (and on timeout when enabled).
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    win       = '0;
    owner_req = |(req_in & gnt_q);
    // After a tenure the scan resumes just past the old owner (RR only).
    rel_ptr   = (RR_MODE != 0) ? ((idx_q == LAST_IDX) ? '0 : idx_q + 1'b1) : rr_ptr_q;
`ifdef PRIORITY_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    others_req = |(req_in & ~gnt_q);
`endif
    case (state_q)
      IDLE: begin
        win = pick_winner(req_in, rr_ptr_q);
        if (win[IDX_W]) begin
          state_d = GRANT;
          gnt_d   = ONE_HOT0 << win[IDX_W-1:0];
          idx_d   = win[IDX_W-1:0];
`ifdef PRIORITY_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Owner released: pass straight to the next requester, else go idle.
          rr_ptr_d = rel_ptr;
          win      = pick_winner(req_in, rel_ptr);
`ifdef PRIORITY_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
          if (win[IDX_W]) begin
            gnt_d = ONE_HOT0 << win[IDX_W-1:0];
            idx_d = win[IDX_W-1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
`ifdef PRIORITY_ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST && others_req) begin
          // Tenure expired with a waiter: force a handover, owner excluded.
          rr_ptr_d   = rel_ptr;
          win        = pick_winner(req_in & ~gnt_q, rel_ptr);
          gnt_d      = ONE_HOT0 << win[IDX_W-1:0];
          idx_d      = win[IDX_W-1:0];
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from the registers.
  always_comb begin
    gnt_out       = gnt_q;
    gnt_idx_out   = idx_q;
    gnt_valid_out = (state_q == GRANT);
`ifdef PRIORITY_ARB_TIMEOUT_EN
    timeout_out   = timeout_q;
`else
    timeout_out   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// tb_priority_grant_arbiter
//   Runs a fixed-priority and a round-robin instance side by side on the same
//   request stream and compares both against a per-cycle behavioural model
//   (owner as an integer, pointer as an integer), plus directed scenarios.
module tb_priority_grant_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;

  logic [N-1:0] gnt_f, gnt_r;
  logic [1:0]   idx_f, idx_r;
  logic         vld_f, vld_r, tmo_f, tmo_r;

  int total = 0;
  int bad   = 0;

  // model state, [0]=fixed, [1]=round-robin
  int m_own[2];
  int m_ptr[2];
  int m_hold[2];
  int m_tmo[2];

  always #5 clk = ~clk;

  priority_grant_arbiter #(.NUM_REQ(N), .RR_MODE(0), .MAX_HOLD(MH)) u_fix (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req),
    .gnt_out(gnt_f), .gnt_idx_out(idx_f), .gnt_valid_out(vld_f), .timeout_out(tmo_f));

  priority_grant_arbiter #(.NUM_REQ(N), .RR_MODE(1), .MAX_HOLD(MH)) u_rr (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req),
    .gnt_out(gnt_r), .gnt_idx_out(idx_r), .gnt_valid_out(vld_r), .timeout_out(tmo_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // first requester in scan order, skipping index 'skip'; -1 if none
  function automatic int pick(input logic [N-1:0] r, input int ptr, input int rr, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (ptr + k) % N : k;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_ptr[m] = 0; m_hold[m] = 0; m_tmo[m] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] r);
    for (int m = 0; m < 2; m++) begin
      m_tmo[m] = 0;
      if (m_own[m] < 0) begin
        m_own[m]  = pick(r, m_ptr[m], m, -1);
        m_hold[m] = 0;
      end else if (!r[m_own[m]]) begin
        if (m == 1) m_ptr[m] = (m_own[m] + 1) % N;
        m_own[m]  = pick(r, m_ptr[m], m, -1);
        m_hold[m] = 0;
      end
`ifdef PRIORITY_ARB_TIMEOUT_EN
      else if (m_hold[m] == MH - 1 && pick(r, 0, 0, m_own[m]) >= 0) begin
        int o;
        o = m_own[m];
        if (m == 1) m_ptr[m] = (o + 1) % N;
        m_own[m]  = pick(r, m_ptr[m], m, o);
        m_hold[m] = 0;
        m_tmo[m]  = 1;
      end else if (m_hold[m] < MH - 1) begin
        m_hold[m]++;
      end
`endif
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg[2];
    int ei[2];
    for (int m = 0; m < 2; m++) begin
      eg[m] = '0;
      ei[m] = 0;
      if (m_own[m] >= 0) begin
        eg[m][m_own[m]] = 1'b1;
        ei[m] = m_own[m];
      end
    end
    chk({tag, ".gnt_f"}, 32'(gnt_f), 32'(eg[0]));
    chk({tag, ".idx_f"}, 32'(idx_f), 32'(ei[0]));
    chk({tag, ".vld_f"}, 32'(vld_f), 32'(m_own[0] >= 0));
    chk({tag, ".tmo_f"}, 32'(tmo_f), 32'(m_tmo[0]));
    chk({tag, ".gnt_r"}, 32'(gnt_r), 32'(eg[1]));
    chk({tag, ".idx_r"}, 32'(idx_r), 32'(ei[1]));
    chk({tag, ".vld_r"}, 32'(vld_r), 32'(m_own[1] >= 0));
    chk({tag, ".tmo_r"}, 32'(tmo_r), 32'(m_tmo[1]));
  endtask

  // one clock: drive req, let the edge happen, advance model, compare
  task automatic cyc(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all(tag);
  endtask

  // asynchronous reset pulse between edges
  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    model_reset();

    // reset held with all requests up
    req = 4'hf;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all("reset");
    end
    rst_n = 1'b1;
    cyc(4'hf, "rel");
    chk("rel.gnt_f", 32'(gnt_f), 32'h1);
    chk("rel.idx_r", 32'(idx_r), 32'h0);

    // fixed priority, no pre-emption, bubble-free handover
    rst_pulse();
    repeat (3) begin
      cyc(4'b0100, "fix");
      chk("fix.hold", 32'(gnt_f), 32'h4);
    end
    cyc(4'b0101, "fix");
    chk("fix.nopre", 32'(gnt_f), 32'h4);
    cyc(4'b0001, "fix");
    chk("fix.handover", 32'(gnt_f), 32'h1);

    // round-robin rotation 0,1,2,3,0
    rst_pulse();
    cyc(4'hf, "rot");
    chk("rot.idx0", 32'(idx_r), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'hf, "rot");
      cyc(4'hf & ~(4'b0001 << i), "rot");
      chk("rot.next", 32'(idx_r), 32'((i + 1) % 4));
    end

    // round-robin wrap and skip: owner 3 releases with 0110 pending
    for (int i = 0; i < 3; i++) begin
      cyc(4'hf, "wrap");
      cyc(4'hf & ~(4'b0001 << i), "wrap");
    end
    chk("wrap.own3", 32'(idx_r), 32'h3);
    cyc(4'hf, "wrap");
    cyc(4'b0110, "wrap");
    chk("wrap.idx", 32'(idx_r), 32'h1);

    // reset in the middle of a tenure
    rst_pulse();
    cyc(4'b1000, "mid");
    cyc(4'b1000, "mid");
    chk("mid.gnt_r", 32'(gnt_r), 32'h8);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid.clr_r", 32'(gnt_r), 32'h0);
    chk("mid.clr_f", 32'(gnt_f), 32'h0);
    check_all("mid.arst");
    #2;
    rst_n = 1'b1;
    cyc(4'b1010, "mid");
    chk("mid.rrptr", 32'(idx_r), 32'h1);

`ifdef PRIORITY_ARB_TIMEOUT_EN
    // forced handover after MAX_HOLD cycles
    rst_pulse();
    repeat (4) begin
      cyc(4'b0011, "tmo");
      chk("tmo.hold", 32'(gnt_f), 32'h1);
    end
    cyc(4'b0011, "tmo");
    chk("tmo.gnt_f", 32'(gnt_f), 32'h2);
    chk("tmo.pulse_f", 32'(tmo_f), 32'h1);
    chk("tmo.pulse_r", 32'(tmo_r), 32'h1);
    cyc(4'b0011, "tmo");
    chk("tmo.once", 32'(tmo_f), 32'h0);
    // lone requester keeps the grant indefinitely
    rst_pulse();
    repeat (10) begin
      cyc(4'b0001, "tmo.solo");
      chk("tmo.solo.gnt", 32'(gnt_f), 32'h1);
      chk("tmo.solo.pulse", 32'(tmo_f), 32'h0);
    end
`else
    // unlimited tenure
    rst_pulse();
    repeat (8) begin
      cyc(4'b0011, "hold");
      chk("hold.gnt_f", 32'(gnt_f), 32'h1);
      chk("hold.gnt_r", 32'(gnt_r), 32'h1);
    end
`endif

    // randomized traffic with sticky request patterns and occasional resets
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 249) == 0) rst_pulse();
      cyc(r, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
